// File: rtl/ccff_chain_loader_pkg.sv
// Shared configuration-chain definitions: loader state encoding and the CRC-16-CCITT
// constants plus a single-bit CRC step used by both the serial CRC and the final compare.
package fpga_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration word stream into the chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  // A word transfers on a rising clock edge where cfg_valid && cfg_ready; the source
  // may raise cfg_valid at any time, cfg_ready is a pure function of loader state.
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator; clear has priority over an update.
module ccff_crc16_serial
  import fpga_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words MSB-first into the ccff scan chain, with an optional
// recirculating verify pass that compares CRCs of loaded and returned bits.
module ccff_chain_loader
  import fpga_cfg_pkg::*;
#(
  parameter int  CHAIN_LEN = 64,
  parameter int  WORD_W    = 32,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             prog_clk,
  input  logic             pReset,
  ccff_chain_loader_if.slave cfg,
  input  logic             start,
  input  logic             verify_en,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [CNT_W-1:0] bit_count,
  output state_t           state
);

  localparam int BL_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] word_buf;
  logic [BL_W-1:0]   bits_left;
  logic              verify_q;
  logic [15:0]       crc_load;
  logic [15:0]       crc_vfy;
  logic              start_acc;
  logic              load_shift;
  logic              need_more;
  logic              last_bit;
  logic              accept;

  always_comb begin
    start_acc  = start && ((state == IDLE) || (state == DONE));
    load_shift = (state == LOAD) && (bits_left != '0) && (32'(bit_count) < 32'(CHAIN_LEN));
    // Bits already shifted plus bits still buffered tell whether another word is due.
    need_more  = (32'(bit_count) + 32'(bits_left)) < 32'(CHAIN_LEN);
    last_bit   = (bit_count == CNT_W'(CHAIN_LEN - 1));
    ccff_shift_en = load_shift || (state == VERIFY);
    ccff_head  = 1'b0;
    if (state == LOAD) begin
      ccff_head = word_buf[WORD_W-1];
    end else if (state == VERIFY) begin
      ccff_head = ccff_tail;
    end
    busy = (state == LOAD) || (state == VERIFY);
    done = (state == DONE);
  end

  assign cfg.cfg_ready = (state == LOAD) && need_more &&
                         ((bits_left == '0) || ((bits_left == BL_W'(1)) && load_shift));
  assign accept = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      bit_count <= '0;
      word_buf  <= '0;
      bits_left <= '0;
      verify_q  <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            bit_count <= '0;
            bits_left <= '0;
            verify_q  <= verify_en;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
          end
        end
        LOAD: begin
          // A refill on the last buffered bit replaces the shift, so no bubble appears.
          if (accept) begin
            word_buf  <= cfg.cfg_data;
            bits_left <= BL_W'(WORD_W);
          end else if (load_shift) begin
            word_buf  <= word_buf << 1;
            bits_left <= bits_left - 1'b1;
          end
          if (load_shift) begin
            bit_count <= bit_count + 1'b1;
            if (last_bit) begin
              bits_left <= '0;
              if (verify_q) begin
                state     <= VERIFY;
                bit_count <= '0;
              end else begin
                state <= DONE;
              end
            end
          end
        end
        VERIFY: begin
          bit_count <= bit_count + 1'b1;
          if (last_bit) begin
            // The verify CRC register has not absorbed the final tail bit yet.
            state   <= DONE;
            crc_ok  <= (crc_load == crc16_step(crc_vfy, ccff_tail));
            crc_err <= (crc_load != crc16_step(crc_vfy, ccff_tail));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ccff_crc16_serial u_crc_load (
    .clk    (prog_clk),
    .reset  (pReset),
    .clear  (start_acc),
    .en     (load_shift),
    .bit_in (ccff_head),
    .crc    (crc_load)
  );

  ccff_crc16_serial u_crc_vfy (
    .clk    (prog_clk),
    .reset  (pReset),
    .clear  (start_acc),
    .en     (state == VERIFY),
    .bit_in (ccff_tail),
    .crc    (crc_vfy)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 64-bit chain with a behavioural chain model, plus a
// 40-bit instance for the truncated final word.
module tb_ccff_chain_loader;
  import fpga_cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic prog_clk = 1'b0;
  logic pReset;
  always #5 prog_clk = ~prog_clk;

  // ---------------- DUT A: 64-bit chain ----------------
  logic       start_a, verify_en_a, ccff_head_a, ccff_shift_en_a, ccff_tail_a;
  logic       busy_a, done_a, crc_ok_a, crc_err_a;
  logic [6:0] bit_count_a;
  state_t     state_a;
  ccff_chain_loader_if #(.WORD_W(32)) cfg_a ();

  ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(32)) u_dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .cfg(cfg_a), .start(start_a),
    .verify_en(verify_en_a), .ccff_head(ccff_head_a), .ccff_shift_en(ccff_shift_en_a),
    .ccff_tail(ccff_tail_a), .busy(busy_a), .done(done_a), .crc_ok(crc_ok_a),
    .crc_err(crc_err_a), .bit_count(bit_count_a), .state(state_a)
  );

  // Chain model: FF0 takes ccff_head, FF63 drives ccff_tail, optional FF17 stuck-at-0.
  logic [63:0] chain_a = '0;
  logic        stuck_a = 1'b0;
  assign ccff_tail_a = chain_a[63];
  always @(posedge prog_clk) begin
    if (ccff_shift_en_a) chain_a <= {chain_a[62:0], ccff_head_a};
    if (stuck_a) chain_a[17] <= 1'b0;
  end

  // ---------------- DUT B: 40-bit chain ----------------
  logic       start_b, verify_en_b, ccff_head_b, ccff_shift_en_b, ccff_tail_b;
  logic       busy_b, done_b, crc_ok_b, crc_err_b;
  logic [5:0] bit_count_b;
  state_t     state_b;
  ccff_chain_loader_if #(.WORD_W(32)) cfg_b ();
  assign ccff_tail_b = 1'b0;

  ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) u_dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .cfg(cfg_b), .start(start_b),
    .verify_en(verify_en_b), .ccff_head(ccff_head_b), .ccff_shift_en(ccff_shift_en_b),
    .ccff_tail(ccff_tail_b), .busy(busy_b), .done(done_b), .crc_ok(crc_ok_b),
    .crc_err(crc_err_b), .bit_count(bit_count_b), .state(state_b)
  );

  // ---------------- scoreboard ----------------
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_bits[$];
  logic tail_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_q(input logic q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) c = (c[15] ^ q[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     64'(busy_a), 64'd0);
    check({tag, "_done"},     64'(done_a), 64'd0);
    check({tag, "_crc_ok"},   64'(crc_ok_a), 64'd0);
    check({tag, "_crc_err"},  64'(crc_err_a), 64'd0);
    check({tag, "_shift_en"}, 64'(ccff_shift_en_a), 64'd0);
    check({tag, "_head"},     64'(ccff_head_a), 64'd0);
    check({tag, "_ready"},    64'(cfg_a.cfg_ready), 64'd0);
    check({tag, "_bit_count"},64'(bit_count_a), 64'd0);
    check({tag, "_state"},    64'(state_a), 64'(IDLE));
  endtask

  // ---------------- driver: one full pass on DUT A ----------------
  task automatic run_a(input logic [31:0] w0, input logic [31:0] w1, input logic v,
                       input int g0, input int g1, input logic stuck, input logic bstart,
                       output int done_cyc, output logic ok, output logic err);
    logic [63:0] exp_vec, cap_vec;
    int widx, gap_left, shifts, ready_cnt, stall_cnt, frozen_bad;
    exp_bits.delete();
    tail_q.delete();
    for (int b = 31; b >= 0; b--) exp_bits.push_back(w0[b]);
    for (int b = 31; b >= 0; b--) exp_bits.push_back(w1[b]);
    exp_vec = '0;
    for (int k = 0; k < 64; k++) exp_vec = {exp_vec[62:0], exp_bits[k]};
    cap_vec = '0; widx = 0; gap_left = g0; shifts = 0;
    ready_cnt = 0; stall_cnt = 0; frozen_bad = 0; done_cyc = -1;
    stuck_a = stuck;
    @(negedge prog_clk);
    start_a = 1'b1; verify_en_a = v; cfg_a.cfg_valid = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge prog_clk);
      start_a = bstart && (c == 10);
      verify_en_a = ~v;
      if (done_a) begin
        done_cyc = c;
        break;
      end
      if (ccff_shift_en_a) begin
        if (shifts < 64) cap_vec = {cap_vec[62:0], ccff_head_a};
        else tail_q.push_back(ccff_tail_a);
        shifts++;
      end else if (busy_a && shifts > 0 && shifts < 64) begin
        stall_cnt++;
        if (32'(bit_count_a) != shifts) frozen_bad++;
      end
      if (cfg_a.cfg_ready) ready_cnt++;
      if (gap_left > 0) begin
        cfg_a.cfg_valid = 1'b0;
        if (cfg_a.cfg_ready) gap_left--;
      end else begin
        cfg_a.cfg_valid = (widx < 2);
        cfg_a.cfg_data  = (widx == 0) ? w0 : w1;
      end
      if (cfg_a.cfg_valid && cfg_a.cfg_ready) begin
        widx++;
        gap_left = g1;
      end
    end
    start_a = 1'b0;
    cfg_a.cfg_valid = 1'b0;
    if (done_cyc < 0) check("done_timeout", 64'(shifts), 64'd9999);
    check("load_stream", cap_vec, exp_vec);
    check("ready_cycles", 64'(ready_cnt), 64'(2 + g0 + g1));
    check("stall_cycles", 64'(stall_cnt), 64'(g1));
    check("stall_bit_count_frozen", 64'(frozen_bad), 64'd0);
    check("done_bit_count", 64'(bit_count_a), 64'd64);
    check("busy_in_done", 64'(busy_a), 64'd0);
    if (v) check("verify_shifts", 64'(tail_q.size()), 64'd64);
    if (!stuck) check("chain_contents", chain_a, exp_vec);
    ok  = crc_ok_a;
    err = crc_err_a;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] w0, w1;
    logic        verify;
    int          gap0, gap1;
    logic        stuck, busy_start;
    int          exp_done;
    logic        exp_ok, exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int   dc;
    logic ok, err;
    logic [31:0] rw0, rw1, wb0, wb1;
    logic rv, rs, match;
    int   rg0, rg1, acc, shb, dcb;
    logic [39:0] cap_b;

    tbl[0] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 0, 0, 1'b0, 1'b0,  66, 1'b0, 1'b0};
    tbl[1] = '{32'hDEADBEEF, 32'h12345678, 1'b1, 0, 0, 1'b0, 1'b0, 130, 1'b1, 1'b0};
    tbl[2] = '{32'hDEADBEEF, 32'h12345678, 1'b1, 0, 0, 1'b1, 1'b0, 130, 1'b0, 1'b1};
    tbl[3] = '{32'hDEADBEEF, 32'h12345678, 1'b1, 0, 5, 1'b0, 1'b0, 135, 1'b1, 1'b0};
    tbl[4] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 0, 0, 1'b0, 1'b1,  66, 1'b0, 1'b0};
    tbl[5] = '{32'hA5A50F0F, 32'h00FF00FF, 1'b0, 3, 0, 1'b0, 1'b0,  69, 1'b0, 1'b0};

    pReset = 1'b1;
    start_a = 1'b0; verify_en_a = 1'b0; cfg_a.cfg_valid = 1'b0; cfg_a.cfg_data = '0;
    start_b = 1'b0; verify_en_b = 1'b0; cfg_b.cfg_valid = 1'b0; cfg_b.cfg_data = '0;
    repeat (3) @(negedge prog_clk);
    check_idle("reset");
    pReset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_a(tbl[i].w0, tbl[i].w1, tbl[i].verify, tbl[i].gap0, tbl[i].gap1,
            tbl[i].stuck, tbl[i].busy_start, dc, ok, err);
      check($sformatf("tbl%0d_done_cycle", i), 64'(dc), 64'(tbl[i].exp_done));
      check($sformatf("tbl%0d_crc_ok", i), 64'(ok), 64'(tbl[i].exp_ok));
      check($sformatf("tbl%0d_crc_err", i), 64'(err), 64'(tbl[i].exp_err));
    end
    stuck_a = 1'b0;

    // Randomised passes against the reference model.
    for (int r = 0; r < 6; r++) begin
      rw0 = $urandom; rw1 = $urandom;
      rv  = 1'($urandom_range(0, 1));
      rg0 = $urandom_range(0, 4); rg1 = $urandom_range(0, 4);
      rs  = ($urandom_range(0, 3) == 0);
      run_a(rw0, rw1, rv, rg0, rg1, rs, 1'b0, dc, ok, err);
      match = (crc_q(exp_bits) == crc_q(tail_q));
      check($sformatf("rnd%0d_done_cycle", r), 64'(dc), 64'(66 + rg0 + rg1 + (rv ? 64 : 0)));
      check($sformatf("rnd%0d_crc_ok", r), 64'(ok), 64'(rv && match));
      check($sformatf("rnd%0d_crc_err", r), 64'(err), 64'(rv && !match));
    end
    stuck_a = 1'b0;

    // Reset in the middle of a load, then a clean load.
    @(negedge prog_clk);
    start_a = 1'b1; verify_en_a = 1'b1;
    cfg_a.cfg_valid = 1'b1; cfg_a.cfg_data = 32'hCAFEF00D;
    dc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge prog_clk);
      start_a = 1'b0;
      if (bit_count_a == 7'd20) begin
        dc = c;
        break;
      end
    end
    if (dc < 0) check("mid_reset_timeout", 64'(bit_count_a), 64'd20);
    pReset = 1'b1;
    #1;
    check_idle("mid_reset");
    @(negedge prog_clk);
    pReset = 1'b0;
    cfg_a.cfg_valid = 1'b0;
    run_a(32'hDEADBEEF, 32'h12345678, 1'b0, 0, 0, 1'b0, 1'b0, dc, ok, err);
    check("after_reset_done_cycle", 64'(dc), 64'd66);
    check("after_reset_crc_ok", 64'(ok), 64'd0);
    check("after_reset_crc_err", 64'(err), 64'd0);

    // 40-bit chain: second word only partially shifted.
    wb0 = $urandom; wb1 = $urandom;
    acc = 0; shb = 0; dcb = -1; cap_b = '0;
    @(negedge prog_clk);
    start_b = 1'b1; cfg_b.cfg_valid = 1'b1; cfg_b.cfg_data = wb0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge prog_clk);
      start_b = 1'b0;
      if (done_b) begin
        dcb = c;
        break;
      end
      if (ccff_shift_en_b) begin
        cap_b = {cap_b[38:0], ccff_head_b};
        shb++;
      end
      cfg_b.cfg_valid = 1'b1;
      cfg_b.cfg_data  = (acc == 0) ? wb0 : ((acc == 1) ? wb1 : 32'hFFFF_FFFF);
      if (cfg_b.cfg_ready) acc++;
    end
    cfg_b.cfg_valid = 1'b0;
    check("b_done_cycle", 64'(dcb), 64'd42);
    check("b_words_accepted", 64'(acc), 64'd2);
    check("b_shifts", 64'(shb), 64'd40);
    check("b_done_bit_count", 64'(bit_count_b), 64'd40);
    check("b_stream", 64'(cap_b), 64'({wb0, wb1[31:24]}));
    check("b_crc_flags", 64'({crc_ok_b, crc_err_b}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
